// File: rtl/puf_soc_resp_gen_if.sv
// Response word handshake between puf_soc_resp_gen and its consumer.
// The generator drives the word and valid; the consumer drives ready.
interface puf_soc_resp_gen_if #(
   parameter int RESP_BITS = 32
);
   logic [RESP_BITS-1:0] o_resp;
   logic                 o_resp_valid;
   logic                 i_resp_ready;

   modport master (output o_resp, output o_resp_valid, input  i_resp_ready);
   modport slave  (input  o_resp, input  o_resp_valid, output i_resp_ready);
endinterface

// File: rtl/puf_soc_resp_gen.sv
// PUF response generator: steps through RESP_BITS ring-oscillator pairs, compares
// counter A against counter B for each pair, and packs the results into one word.
module puf_soc_resp_gen #(
   parameter int CNT_BIT_SIZE = 32,
   parameter int RESP_BITS    = 32,
   parameter int IDX_W        = $clog2(RESP_BITS),
   parameter int TIMEOUT_CYC  = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   output logic                    o_cnt_en,
   output logic [IDX_W-1:0]        o_pair_idx,
   input  logic                    i_a_valid,
   input  logic [CNT_BIT_SIZE-1:0] i_a_cnt,
   input  logic                    i_a_full,
   input  logic                    i_b_valid,
   input  logic [CNT_BIT_SIZE-1:0] i_b_cnt,
   input  logic                    i_b_full,
   output logic                    o_busy,
   output logic [IDX_W:0]          o_tie_cnt,
   output logic                    o_sat,
   output logic                    o_timeout,
   puf_soc_resp_gen_if.master      resp_if
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);

   typedef enum logic [1:0] {IDLE, MEASURE, COMPARE, DONE} state_t;

   state_t                  state;
   logic [RESP_BITS-1:0]    resp_q;
   logic                    resp_valid_q;
   logic [TO_W-1:0]         to_cnt;
   logic                    a_cap_p0;
   logic                    b_cap_p0;
   logic [CNT_BIT_SIZE-1:0] a_cnt_p0;
   logic [CNT_BIT_SIZE-1:0] b_cnt_p0;
   logic                    a_full_p0;
   logic                    b_full_p0;
   logic                    a_got;
   logic                    b_got;

   function automatic logic resp_bit(input logic [CNT_BIT_SIZE-1:0] a,
                                     input logic [CNT_BIT_SIZE-1:0] b);
      return (a > b);
   endfunction

   assign resp_if.o_resp       = resp_q;
   assign resp_if.o_resp_valid = resp_valid_q;

   // A side counts as present if captured earlier or arriving this cycle
   assign a_got = a_cap_p0 | i_a_valid;
   assign b_got = b_cap_p0 | i_b_valid;

   // ---- capture stage (p0): first valid of each side per bit, data not reset
   always_ff @(posedge clk) begin
      if (state == MEASURE && !a_cap_p0 && i_a_valid) begin
         a_cnt_p0  <= i_a_cnt;
         a_full_p0 <= i_a_full;
      end
      if (state == MEASURE && !b_cap_p0 && i_b_valid) begin
         b_cnt_p0  <= i_b_cnt;
         b_full_p0 <= i_b_full;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         o_cnt_en     <= 1'b0;
         o_pair_idx   <= '0;
         resp_q       <= '0;
         resp_valid_q <= 1'b0;
         o_busy       <= 1'b0;
         o_tie_cnt    <= '0;
         o_sat        <= 1'b0;
         o_timeout    <= 1'b0;
         to_cnt       <= '0;
         a_cap_p0     <= 1'b0;
         b_cap_p0     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  state      <= MEASURE;
                  o_cnt_en   <= 1'b1;
                  o_busy     <= 1'b1;
                  o_pair_idx <= '0;
                  resp_q     <= '0;
                  o_tie_cnt  <= '0;
                  o_sat      <= 1'b0;
                  o_timeout  <= 1'b0;
                  to_cnt     <= '0;
                  a_cap_p0   <= 1'b0;
                  b_cap_p0   <= 1'b0;
               end
            end
            MEASURE: begin
               to_cnt <= to_cnt + 1'b1;
               if (i_a_valid) a_cap_p0 <= 1'b1;
               if (i_b_valid) b_cap_p0 <= 1'b1;
               if (a_got && b_got) begin
                  state    <= COMPARE;
                  o_cnt_en <= 1'b0;
               end else if (to_cnt == TO_LAST) begin
                  // Abort: hand out whatever bits were resolved so far
                  state        <= DONE;
                  o_cnt_en     <= 1'b0;
                  o_timeout    <= 1'b1;
                  resp_valid_q <= 1'b1;
               end
            end
            // ---- compare stage: consumes p0 captures, produces one response bit
            COMPARE: begin
               resp_q[o_pair_idx] <= resp_bit(a_cnt_p0, b_cnt_p0);
               if (a_cnt_p0 == b_cnt_p0) o_tie_cnt <= o_tie_cnt + 1'b1;
               if (a_full_p0 || b_full_p0) o_sat <= 1'b1;
               if (o_pair_idx == IDX_LAST) begin
                  state        <= DONE;
                  resp_valid_q <= 1'b1;
               end else begin
                  state      <= MEASURE;
                  o_cnt_en   <= 1'b1;
                  o_pair_idx <= o_pair_idx + 1'b1;
                  to_cnt     <= '0;
                  a_cap_p0   <= 1'b0;
                  b_cap_p0   <= 1'b0;
               end
            end
            DONE: begin
               if (resp_if.i_resp_ready) begin
                  state        <= IDLE;
                  resp_valid_q <= 1'b0;
                  o_busy       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_soc_resp_gen.sv
// Scoreboard bench for puf_soc_resp_gen driven by a behavioural model of the
// two ring-oscillator counters with per-test latencies and count patterns.
module tb_puf_soc_resp_gen;
   localparam int CW = 32;
   localparam int RB = 32;
   localparam int IW = 5;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic          o_cnt_en;
   logic [IW-1:0] o_pair_idx;
   logic          a_valid = 1'b0, b_valid = 1'b0, a_full = 1'b0, b_full = 1'b0;
   logic [CW-1:0] a_cnt = '0, b_cnt = '0;
   logic          o_busy, o_sat, o_timeout;
   logic [IW:0]   o_tie_cnt;

   always #5 clk = ~clk;

   puf_soc_resp_gen_if #(.RESP_BITS(RB)) resp_if ();

   puf_soc_resp_gen #(.CNT_BIT_SIZE(CW), .RESP_BITS(RB), .IDX_W(IW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start),
      .o_cnt_en(o_cnt_en), .o_pair_idx(o_pair_idx),
      .i_a_valid(a_valid), .i_a_cnt(a_cnt), .i_a_full(a_full),
      .i_b_valid(b_valid), .i_b_cnt(b_cnt), .i_b_full(b_full),
      .o_busy(o_busy), .o_tie_cnt(o_tie_cnt), .o_sat(o_sat), .o_timeout(o_timeout),
      .resp_if(resp_if)
   );

   typedef struct {
      logic [RB-1:0] resp;
      logic [IW:0]   tie;
      logic          sat;
      logic          tmo;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_err = 0;
   int   mode = 0;       // 0 aligned, 1 skewed, 2 tie/sat, 3 timeout on pair 4
   int   en4 = 0;        // cnt_en-high cycles seen while pair_idx==4
   int   gap_viol = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Counter pair model: valid pulses timed from the rising edge of cnt_en
   initial begin
      int en_cyc, p, la, lb;
      logic [CW-1:0] av, bv;
      bit af, bnever;
      en_cyc = 0;
      forever begin
         @(negedge clk);
         if (!o_cnt_en) begin
            en_cyc = 0;
            a_valid = 0; b_valid = 0; a_full = 0; b_full = 0;
         end else begin
            p = int'(o_pair_idx);
            la = 0; lb = 0; af = 0; bnever = 0;
            av = (p % 2 == 0) ? 32'd1000 : 32'd900;
            bv = (p % 2 == 0) ? 32'd900 : 32'd1000;
            if (mode == 1) begin la = (p == 6) ? 2 : 7; lb = (p == 6) ? 2 : 0; end
            if (mode == 2 && p == 3) begin av = 32'd512; bv = 32'd512; end
            if (mode == 2 && p == 9) begin av = 32'd1024; bv = 32'd10; af = 1; end
            if (mode == 3 && p == 4) bnever = 1;
            a_valid = (en_cyc == la);
            a_cnt   = (en_cyc == la) ? av : 32'hDEAD;
            a_full  = (en_cyc == la) && af;
            // skewed mode re-pulses B with a bogus count that must be ignored
            b_valid = !bnever && ((en_cyc == lb) || (mode == 1 && p != 6 && en_cyc == 3));
            b_cnt   = (en_cyc == lb) ? bv : 32'd5000;
            b_full  = 1'b0;
            en_cyc++;
         end
      end
   end

   initial begin
      logic [IW-1:0] prev_idx;
      logic prev_en;
      prev_idx = '0; prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (o_cnt_en && o_pair_idx == 5'd4) en4++;
         if (o_pair_idx != prev_idx && o_busy && prev_en) gap_viol++;
         prev_idx = o_pair_idx;
         prev_en  = o_cnt_en;
      end
   end

   // Scoreboard monitor: one pop per accepted word
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && resp_if.o_resp_valid && resp_if.i_resp_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL sb_unexpected: got word %0h expected none", resp_if.o_resp);
            end else begin
               e = sb_q.pop_front();
               check("sb_resp", 64'(resp_if.o_resp), 64'(e.resp));
               check("sb_tie", 64'(o_tie_cnt), 64'(e.tie));
               check("sb_sat", 64'(o_sat), 64'(e.sat));
               check("sb_timeout", 64'(o_timeout), 64'(e.tmo));
            end
         end
      end
   end

   task automatic push_exp(input logic [RB-1:0] r, input int tie, input bit sat, input bit tmo);
      exp_t e;
      e.resp = r; e.tie = (IW+1)'(tie); e.sat = sat; e.tmo = tmo;
      sb_q.push_back(e);
   endtask

   task automatic start_and_wait(output int cyc);
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      cyc = 0;
      while (!resp_if.o_resp_valid && cyc < 2000) begin
         @(posedge clk); #1 cyc++;
      end
      check("valid_wait", 64'(resp_if.o_resp_valid), 64'd1);
   endtask

   task automatic finish_handshake();
      for (int k = 0; k < 10 && resp_if.o_resp_valid; k++) begin
         @(posedge clk); #1;
      end
      check("handshake_drop", 64'(resp_if.o_resp_valid), 64'd0);
      check("busy_after", 64'(o_busy), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cnt_en"}, 64'(o_cnt_en), 64'd0);
      check({tag, "_pair_idx"}, 64'(o_pair_idx), 64'd0);
      check({tag, "_resp"}, 64'(resp_if.o_resp), 64'd0);
      check({tag, "_valid"}, 64'(resp_if.o_resp_valid), 64'd0);
      check({tag, "_busy"}, 64'(o_busy), 64'd0);
      check({tag, "_tie"}, 64'(o_tie_cnt), 64'd0);
      check({tag, "_sat"}, 64'(o_sat), 64'd0);
      check({tag, "_timeout"}, 64'(o_timeout), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, bad;
      logic [RB-1:0] snap;
      resp_if.i_resp_ready = 1'b1;
      #12 check_all_zero("rst");
      @(negedge clk) rst_n = 1'b1;

      // Aligned word, zero counter latency: 2 cycles per bit
      mode = 0;
      push_exp(32'h55555555, 0, 0, 0);
      start_and_wait(cyc);
      check("latency", 64'(cyc), 64'd64);
      finish_handshake();

      // Reset in the middle of bit 5 discards the run
      mode = 0;
      @(posedge clk); #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      bad = 0;
      while (o_pair_idx != 5'd5 && bad < 200) begin @(negedge clk); bad++; end
      check("reach_bit5", 64'(o_pair_idx), 64'd5);
      rst_n = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clk); @(negedge clk) rst_n = 1'b1;
      push_exp(32'h55555555, 0, 0, 0);
      start_and_wait(cyc);
      finish_handshake();

      // Skewed arrival, one same-cycle bit, repeated B pulses
      mode = 1;
      push_exp(32'h55555555, 0, 0, 0);
      start_and_wait(cyc);
      finish_handshake();

      // Tie on pair 3, saturation on pair 9
      mode = 2;
      push_exp(32'h55555755, 1, 1, 0);
      start_and_wait(cyc);
      finish_handshake();

      // B never valid on pair 4
      mode = 3;
      en4 = 0;
      push_exp(32'h00000005, 0, 0, 1);
      start_and_wait(cyc);
      check("timeout_cycles", 64'(en4), 64'd16);
      check("timeout_pair", 64'(o_pair_idx), 64'd4);
      finish_handshake();

      // Back-pressure with an ignored start
      mode = 0;
      resp_if.i_resp_ready = 1'b0;
      push_exp(32'h55555555, 0, 0, 0);
      start_and_wait(cyc);
      snap = resp_if.o_resp;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         i_start = (i == 10);
         if (resp_if.o_resp !== snap || !resp_if.o_resp_valid || !o_busy) bad++;
      end
      i_start = 1'b0;
      check("bp_stable", 64'(bad), 64'd0);
      resp_if.i_resp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_drop", 64'(resp_if.o_resp_valid), 64'd0);
      check("bp_idle", 64'(o_busy), 64'd0);
      @(posedge clk); #1;
      check("bp_start_ignored", 64'(o_busy), 64'd0);
      check("bp_resp_held", 64'(resp_if.o_resp), 64'h55555555);

      check("cnt_en_gap", 64'(gap_viol), 64'd0);
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
